// File: rtl/arb_request_agent.sv
// arb_request_agent: per-channel job counters driving a request vector,
// owner tracking and an optional OWN watchdog (macro ARB_AGENT_TIMEOUT_EN).
module arb_request_agent #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] enq,
  input  logic [WIDTH-1:0] grant,
  input  logic             done,
  output logic [WIDTH-1:0] request,
  output logic [WIDTH-1:0] owner,
  output logic             busy,
  output logic             overflow,
  output logic             grant_err,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] GNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // A zero watchdog limit would release on the very first OWN cycle
  // before any work could happen, so reject it at elaboration.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] request_q, request_d;
  logic [WIDTH-1:0] owner_q, owner_d;
  logic             ovf_q, ovf_d;
  logic             gerr_q, gerr_d;
  logic             accept;
  logic             gnt_onehot;
  logic             wd_expire;
  logic             hold_owner;

  assign gnt_onehot = (grant != '0) &&
                      ((grant & (grant - GNT_ONE)) == '0);

  // Next state, owner capture and illegal-grant detection.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gerr_d  = gerr_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != '0) begin
          if (gnt_onehot && ((grant & request_q) != '0)) begin
            accept  = 1'b1;
            owner_d = grant;
            state_d = OWN;
          end else begin
            gerr_d = 1'b1;
          end
        end
      end
      OWN: begin
        if (done || wd_expire) begin
          state_d = RELEASE;
          owner_d = '0;
        end
      end
      RELEASE: begin
        owner_d = '0;
        state_d = IDLE;
      end
      default: begin
        owner_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Saturating per-channel job counters; enq and accept cancel out.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (enq[i] && !(accept && grant[i])) begin
        if (&cnt_q[i]) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else if (!enq[i] && accept && grant[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Request pending channels, except the owner while it holds the resource.
  always_comb begin
    hold_owner = (state_d == OWN) || (state_d == RELEASE);
    request_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      request_d[i] = (cnt_d[i] != '0) && !(hold_owner && owner_d[i]);
    end
    if (state_d == RELEASE) begin
      request_d = '0;
    end
  end

  // Main state, counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      request_q <= '0;
      owner_q   <= '0;
      ovf_q     <= 1'b0;
      gerr_q    <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      request_q <= request_d;
      owner_q   <= owner_d;
      ovf_q     <= ovf_d;
      gerr_q    <= gerr_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef ARB_AGENT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

  logic [WD_W-1:0] wd_q;
  logic            tmo_q;

  assign wd_expire = (state_q == OWN) && (wd_q == WD_LAST);

  // Count OWN cycles; expiry without done forces release and flags it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      if ((state_q == OWN) && (state_d == OWN)) begin
        wd_q <= wd_q + WD_ONE;
      end else begin
        wd_q <= '0;
      end
      if (wd_expire && !done) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign timeout = tmo_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign request   = request_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;
  assign grant_err = gerr_q;

endmodule

// File: tb/tb_arb_request_agent.sv
// Scoreboard bench for arb_request_agent: stimulus pushes expected
// post-edge outputs, a monitor pops and compares them after each edge.
module tb_arb_request_agent;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] enq = '0;
  logic [7:0] grant = '0;
  logic       done = 1'b0;
  logic [7:0] request;
  logic [7:0] owner;
  logic       busy;
  logic       overflow;
  logic       grant_err;
  logic       timeout;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic x_ov = 1'b0;
  logic x_ge = 1'b0;
  logic x_to = 1'b0;

  typedef struct {
    string      nm;
    int         tag;
    logic [7:0] r;
    logic [7:0] o;
    logic       b;
    logic       ov;
    logic       ge;
    logic       to;
  } exp_t;

  exp_t q[$];

  arb_request_agent #(
    .WIDTH(8),
    .CNT_W(4),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enq(enq),
    .grant(grant),
    .done(done),
    .request(request),
    .owner(owner),
    .busy(busy),
    .overflow(overflow),
    .grant_err(grant_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic cmp(input exp_t e);
    checks++;
    if (request !== e.r || owner !== e.o || busy !== e.b ||
        overflow !== e.ov || grant_err !== e.ge || timeout !== e.to) begin
      errors++;
      $display("FAIL %s cyc=%0d got req=%h own=%h busy=%b ovf=%b gerr=%b tmo=%b want req=%h own=%h busy=%b ovf=%b gerr=%b tmo=%b",
               e.nm, cyc, request, owner, busy, overflow, grant_err,
               timeout, e.r, e.o, e.b, e.ov, e.ge, e.to);
    end
  endtask

  // Monitor: after every rising edge, retire all entries due by now.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].tag <= cyc) begin
        cmp(q.pop_front());
      end
    end
  end

  task automatic step(input logic [7:0] e, input logic [7:0] g,
                      input logic d, input string nm,
                      input logic [7:0] xr, input logic [7:0] xo,
                      input logic xb);
    exp_t x;
    @(negedge clk);
    enq   = e;
    grant = g;
    done  = d;
    x.nm  = nm;
    x.tag = cyc + 1;
    x.r   = xr;
    x.o   = xo;
    x.b   = xb;
    x.ov  = x_ov;
    x.ge  = x_ge;
    x.to  = x_to;
    q.push_back(x);
  endtask

  task automatic now_check(input string nm);
    exp_t x;
    x.nm  = nm;
    x.tag = cyc;
    x.r   = '0;
    x.o   = '0;
    x.b   = 1'b0;
    x.ov  = 1'b0;
    x.ge  = 1'b0;
    x.to  = 1'b0;
    cmp(x);
  endtask

  initial begin
    #2;
    now_check("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic enq -> request -> grant -> own -> release.
    step(8'h04, 8'h00, 0, "enq2_req", 8'h04, 8'h00, 0);
    step(8'h00, 8'h00, 0, "req_hold", 8'h04, 8'h00, 0);
    step(8'h00, 8'h04, 0, "accept2", 8'h00, 8'h04, 1);
    step(8'h00, 8'h00, 0, "own2_hold", 8'h00, 8'h04, 1);
    step(8'h00, 8'h00, 1, "release2", 8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 0, "idle2", 8'h00, 8'h00, 0);

    // Illegal grants leave counters alone; grant change in OWN ignored.
    step(8'h08, 8'h00, 0, "enq3", 8'h08, 8'h00, 0);
    x_ge = 1'b1;
    step(8'h00, 8'h05, 0, "multihot", 8'h08, 8'h00, 0);
    step(8'h00, 8'h01, 0, "nonreq_gnt", 8'h08, 8'h00, 0);
    step(8'h00, 8'h08, 0, "accept3", 8'h00, 8'h08, 1);
    step(8'h00, 8'h10, 0, "own_gnt_chg", 8'h00, 8'h08, 1);
    step(8'h00, 8'h00, 1, "release3", 8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 0, "idle3_empty", 8'h00, 8'h00, 0);

    // Two jobs on ch1, enq coincident with accept keeps count at 2.
    step(8'h02, 8'h00, 0, "enq1_a", 8'h02, 8'h00, 0);
    step(8'h02, 8'h00, 0, "enq1_b", 8'h02, 8'h00, 0);
    step(8'h02, 8'h02, 0, "acc1_enq", 8'h00, 8'h02, 1);
    step(8'h00, 8'h00, 1, "rel1_a", 8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 0, "idle1_a", 8'h02, 8'h00, 0);
    step(8'h00, 8'h02, 0, "acc1_b", 8'h00, 8'h02, 1);
    step(8'h00, 8'h00, 1, "rel1_b", 8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 0, "idle1_b", 8'h02, 8'h00, 0);
    step(8'h00, 8'h02, 0, "acc1_c", 8'h00, 8'h02, 1);
    step(8'h00, 8'h00, 1, "rel1_c", 8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 0, "idle1_c", 8'h00, 8'h00, 0);
    step(8'h00, 8'h00, 1, "done_idle", 8'h00, 8'h00, 0);

    // Saturate ch0: 16 enqs, then exactly 15 drains.
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) x_ov = 1'b1;
      step(8'h01, 8'h00, 0, "sat_enq", 8'h01, 8'h00, 0);
    end
    for (int k = 1; k <= 15; k++) begin
      step(8'h00, 8'h01, 0, "drain_acc", 8'h00, 8'h01, 1);
      step(8'h00, 8'h00, 1, "drain_rel", 8'h00, 8'h00, 1);
      step(8'h00, 8'h00, 0, "drain_idle",
           (k < 15) ? 8'h01 : 8'h00, 8'h00, 0);
    end

    // Watchdog behaviour.
    step(8'h20, 8'h00, 0, "enq5", 8'h20, 8'h00, 0);
    step(8'h00, 8'h20, 0, "acc5", 8'h00, 8'h20, 1);
`ifdef ARB_AGENT_TIMEOUT_EN
    for (int i = 1; i <= 70; i++) begin
      if (i < 64) begin
        step(8'h00, 8'h00, 0, "wd_own", 8'h00, 8'h20, 1);
      end else if (i == 64) begin
        x_to = 1'b1;
        step(8'h00, 8'h00, 0, "wd_release", 8'h00, 8'h00, 1);
      end else begin
        step(8'h00, 8'h00, 0, "wd_idle", 8'h00, 8'h00, 0);
      end
    end
`else
    for (int i = 1; i <= 200; i++) begin
      step(8'h00, 8'h00, 0, "no_wd_own", 8'h00, 8'h20, 1);
    end
    step(8'h00, 8'h00, 1, "no_wd_rel", 8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 0, "no_wd_idle", 8'h00, 8'h00, 0);
`endif

    // Asynchronous reset in the middle of OWN with pending work.
    step(8'h40, 8'h00, 0, "enq6", 8'h40, 8'h00, 0);
    step(8'h80, 8'h00, 0, "enq7", 8'hC0, 8'h00, 0);
    step(8'h00, 8'h40, 0, "acc6", 8'h80, 8'h40, 1);
    @(negedge clk);
    enq   = '0;
    grant = '0;
    done  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    now_check("async_rst");
    x_ov = 1'b0;
    x_ge = 1'b0;
    x_to = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(8'h00, 8'h00, 0, "post_rst", 8'h00, 8'h00, 0);
    step(8'h01, 8'h00, 0, "first_enq", 8'h01, 8'h00, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
